// File: rtl/pixel_frame_loader_if.sv
// Pixel stream, image-memory write port and median-stage control for pixel_frame_loader.
// The loader uses the slave modport; the producer/consumer side uses master.
interface pixel_frame_loader_if;
  logic       pixValid;
  logic       pixSof;
  logic [7:0] pixData;
  logic       pixReady;
  logic [7:0] binLevel;
  logic       filterDone;
  logic       writeMem;
  logic [7:0] xAddressIn;
  logic [7:0] yAddressIn;
  logic       dataIn;
  logic       start;
  logic       busy;
  logic       frameErr;

  modport slave (
    input  pixValid, pixSof, pixData, binLevel, filterDone,
    output pixReady, writeMem, xAddressIn, yAddressIn, dataIn, start, busy, frameErr
  );

  modport master (
    output pixValid, pixSof, pixData, binLevel, filterDone,
    input  pixReady, writeMem, xAddressIn, yAddressIn, dataIn, start, busy, frameErr
  );
endinterface

// File: rtl/pixel_frame_loader.sv
// Binarises a raster pixel stream into the 1-bit image memory, then launches the median
// pass with a start pulse and back-pressures the stream until the pass reports done.
module pixel_frame_loader #(
  parameter int unsigned IMG_WIDTH  = 160,
  parameter int unsigned IMG_HEIGHT = 120
) (
  input logic                  clk,
  input logic                  reset,
  pixel_frame_loader_if.slave  bus
);

  localparam logic [7:0] XLast = 8'(IMG_WIDTH - 1);
  localparam logic [7:0] YLast = 8'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StStart, StWait} state_e;

  state_e     r_state;
  logic [7:0] r_x_cnt;
  logic [7:0] r_y_cnt;
  logic       r_write_mem;
  logic [7:0] r_x_addr;
  logic [7:0] r_y_addr;
  logic       r_data;
  logic       r_start;
  logic       r_frame_err;

  logic       w_ready;
  logic       w_accept;
  logic       w_write;
  logic [7:0] w_x_pos;
  logic [7:0] w_y_pos;
  logic       w_bin;
  logic       w_line_end;
  logic       w_frame_end;

  assign w_ready  = (r_state == StIdle) || (r_state == StLoad);
  assign w_accept = bus.pixValid && w_ready;
  // In IDLE only a start-of-frame pixel is stored; anything else is dropped.
  assign w_write  = w_accept && (bus.pixSof || (r_state == StLoad));

  // A start-of-frame pixel always lands at (0,0), also as resync inside a frame.
  assign w_x_pos     = bus.pixSof ? 8'd0 : r_x_cnt;
  assign w_y_pos     = bus.pixSof ? 8'd0 : r_y_cnt;
  assign w_bin       = bus.pixData >= bus.binLevel;
  assign w_line_end  = w_x_pos == XLast;
  assign w_frame_end = w_line_end && (w_y_pos == YLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_x_cnt     <= 8'd0;
      r_y_cnt     <= 8'd0;
      r_write_mem <= 1'b0;
      r_x_addr    <= 8'd0;
      r_y_addr    <= 8'd0;
      r_data      <= 1'b0;
      r_start     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_write_mem <= 1'b0;
      r_start     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        StIdle, StLoad: begin
          if (w_write) begin
            r_write_mem <= 1'b1;
            r_x_addr    <= w_x_pos;
            r_y_addr    <= w_y_pos;
            r_data      <= w_bin;
            r_frame_err <= bus.pixSof && (r_state == StLoad);
            if (w_frame_end) begin
              r_x_cnt <= 8'd0;
              r_y_cnt <= 8'd0;
              r_state <= StStart;
            end else if (w_line_end) begin
              r_x_cnt <= 8'd0;
              r_y_cnt <= 8'(w_y_pos + 8'd1);
              r_state <= StLoad;
            end else begin
              r_x_cnt <= 8'(w_x_pos + 8'd1);
              r_y_cnt <= w_y_pos;
              r_state <= StLoad;
            end
          end
        end
        // The last write is on the bus during this state; start follows one cycle later.
        StStart: begin
          r_start <= 1'b1;
          r_state <= StWait;
        end
        StWait: begin
          if (bus.filterDone) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.pixReady   = w_ready;
  assign bus.busy       = r_state != StIdle;
  assign bus.writeMem   = r_write_mem;
  assign bus.xAddressIn = r_x_addr;
  assign bus.yAddressIn = r_y_addr;
  assign bus.dataIn     = r_data;
  assign bus.start      = r_start;
  assign bus.frameErr   = r_frame_err;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed bench for pixel_frame_loader: a 4x3 instance for the frame-sequencing corners
// and a default 160x120 instance for reset abort and a full frame with random gaps.
module tb_pixel_frame_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pixel_frame_loader_if bus_s ();
  pixel_frame_loader_if bus_b ();

  pixel_frame_loader #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s.slave)
  );

  pixel_frame_loader dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       d;
    int         c;
  } wr_t;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic [7:0] lvl;
    logic [7:0] ex;
    logic [7:0] ey;
    logic       ed;
  } vec_t;

  // Small-DUT observer.
  wr_t wq_s[$];
  int  starts_s = 0, start_cyc_s = 0, errs_s = 0, err_cyc_s = 0;
  always @(negedge clk) begin
    if (bus_s.writeMem)
      wq_s.push_back('{x: bus_s.xAddressIn, y: bus_s.yAddressIn, d: bus_s.dataIn, c: cyc});
    if (bus_s.start) begin
      starts_s++;
      start_cyc_s = cyc;
    end
    if (bus_s.frameErr) begin
      errs_s++;
      err_cyc_s = cyc;
    end
  end

  // Big-DUT scoreboard: each write is matched against the next expected pixel.
  wr_t        eq_b[$];
  int         wr_b = 0, mis_b = 0, starts_b = 0;
  logic [7:0] lastx_b = 8'd0, lasty_b = 8'd0;
  always @(negedge clk) begin
    wr_t e;
    if (bus_b.writeMem) begin
      wr_b++;
      lastx_b = bus_b.xAddressIn;
      lasty_b = bus_b.yAddressIn;
      if (eq_b.size() == 0) begin
        mis_b++;
      end else begin
        e = eq_b.pop_front();
        if (e.x !== bus_b.xAddressIn || e.y !== bus_b.yAddressIn || e.d !== bus_b.dataIn)
          mis_b++;
      end
    end
    if (bus_b.start) starts_b++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic send_s(input logic [7:0] d, input logic sof, input logic [7:0] lvl);
    bus_s.pixValid = 1'b1;
    bus_s.pixSof   = sof;
    bus_s.pixData  = d;
    bus_s.binLevel = lvl;
    @(posedge clk);
    #1;
    bus_s.pixValid = 1'b0;
    bus_s.pixSof   = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic sof, input logic [7:0] lvl,
                        input logic [7:0] ex, input logic [7:0] ey);
    bus_b.pixValid = 1'b1;
    bus_b.pixSof   = sof;
    bus_b.pixData  = d;
    bus_b.binLevel = lvl;
    eq_b.push_back('{x: ex, y: ey, d: (d >= lvl), c: 0});
    @(posedge clk);
    #1;
    bus_b.pixValid = 1'b0;
    bus_b.pixSof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic done_s();
    bus_s.filterDone = 1'b1;
    @(posedge clk);
    #1;
    bus_s.filterDone = 1'b0;
  endtask

  task automatic clear_s();
    wq_s.delete();
    starts_s = 0;
    errs_s   = 0;
  endtask

  vec_t t2[12];
  vec_t t3[12];

  initial begin
    int rdy_seen;
    bus_s.pixValid = 0; bus_s.pixSof = 0; bus_s.pixData = 0; bus_s.binLevel = 0;
    bus_s.filterDone = 0;
    bus_b.pixValid = 0; bus_b.pixSof = 0; bus_b.pixData = 0; bus_b.binLevel = 0;
    bus_b.filterDone = 0;

    // i*20 against level 100: ones from i=5 (100) onward.
    for (int i = 0; i < 12; i++)
      t2[i] = '{d: 8'(i * 20), sof: (i == 0), lvl: 8'd100,
                ex: 8'(i % 4), ey: 8'(i / 4), ed: (i >= 5)};
    // Level boundaries and a level change on every pixel.
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0:       t3[i] = '{d: 8'd255, sof: (i == 0), lvl: 8'd255, ex: 0, ey: 0, ed: 1'b1};
        1:       t3[i] = '{d: 8'd254, sof: 1'b0, lvl: 8'd255, ex: 0, ey: 0, ed: 1'b0};
        default: t3[i] = '{d: 8'd0,   sof: 1'b0, lvl: 8'd0,   ex: 0, ey: 0, ed: 1'b1};
      endcase
      t3[i].ex = 8'(i % 4);
      t3[i].ey = 8'(i / 4);
    end

    // Reset state.
    idle(2);
    chk("rst_write", bus_s.writeMem, 0);
    chk("rst_start", bus_s.start, 0);
    chk("rst_busy", bus_s.busy, 0);
    chk("rst_err", bus_s.frameErr, 0);
    chk("rst_data", bus_s.dataIn, 0);
    chk("rst_xy", {bus_s.xAddressIn, bus_s.yAddressIn}, 0);
    chk("rst_ready", bus_s.pixReady, 1);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // 4x3 frame, raster order, start one cycle after the last write.
    clear_s();
    for (int i = 0; i < 12; i++) send_s(t2[i].d, t2[i].sof, t2[i].lvl);
    idle(3);
    chk("t2_count", wq_s.size(), 12);
    for (int i = 0; i < 12 && i < wq_s.size(); i++) begin
      chk($sformatf("t2_x%0d", i), wq_s[i].x, t2[i].ex);
      chk($sformatf("t2_y%0d", i), wq_s[i].y, t2[i].ey);
      chk($sformatf("t2_d%0d", i), wq_s[i].d, t2[i].ed);
    end
    chk("t2_starts", starts_s, 1);
    if (wq_s.size() == 12) chk("t2_start_cyc", start_cyc_s, wq_s[11].c + 1);
    chk("t2_busy", bus_s.busy, 1);

    // Back-pressure in WAIT.
    clear_s();
    rdy_seen = 0;
    bus_s.pixValid = 1'b1;
    bus_s.pixData  = 8'd200;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus_s.pixReady) rdy_seen++;
    end
    bus_s.pixValid = 1'b0;
    idle(2);
    chk("t5_ready_seen", rdy_seen, 0);
    chk("t5_writes", wq_s.size(), 0);
    chk("t5_starts", starts_s, 0);
    done_s();
    chk("t5_ready_after", bus_s.pixReady, 1);
    chk("t5_busy_after", bus_s.busy, 0);

    // Pixels before start-of-frame are discarded.
    clear_s();
    for (int i = 0; i < 3; i++) send_s(8'd255, 1'b0, 8'd0);
    idle(2);
    chk("t3_dropped", wq_s.size(), 0);
    chk("t3_idle", bus_s.busy, 0);
    for (int i = 0; i < 12; i++) send_s(t3[i].d, t3[i].sof, t3[i].lvl);
    idle(3);
    chk("t3_count", wq_s.size(), 12);
    for (int i = 0; i < 12 && i < wq_s.size(); i++) begin
      chk($sformatf("t3_xy%0d", i), {wq_s[i].x, wq_s[i].y}, {t3[i].ex, t3[i].ey});
      chk($sformatf("t3_d%0d", i), wq_s[i].d, t3[i].ed);
    end
    chk("t3_starts", starts_s, 1);
    done_s();

    // Resync on a stray start-of-frame at pixel 7.
    clear_s();
    for (int i = 0; i < 7; i++) send_s(8'd200, (i == 0), 8'd100);
    send_s(8'd200, 1'b1, 8'd100);
    for (int i = 0; i < 10; i++) send_s(8'd200, 1'b0, 8'd100);
    idle(3);
    chk("t4_no_start_yet", starts_s, 0);
    chk("t4_errs", errs_s, 1);
    if (wq_s.size() > 7) begin
      chk("t4_px7_xy", {wq_s[7].x, wq_s[7].y}, 0);
      chk("t4_err_cyc", err_cyc_s, wq_s[7].c);
    end else begin
      chk("t4_px7_written", wq_s.size(), 18);
    end
    send_s(8'd200, 1'b0, 8'd100);
    idle(3);
    chk("t4_starts", starts_s, 1);
    chk("t4_count", wq_s.size(), 19);
    if (wq_s.size() == 19) chk("t4_last_xy", {wq_s[18].x, wq_s[18].y}, {8'd3, 8'd2});
    chk("t4_errs_final", errs_s, 1);
    done_s();

    // Reset in the middle of a 160x120 frame.
    for (int i = 0; i < 50; i++) send_b(8'(i * 5), (i == 0), 8'd128, 8'(i), 8'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("t1_rst_write", bus_b.writeMem, 0);
    chk("t1_rst_busy", bus_b.busy, 0);
    chk("t1_rst_xy", {bus_b.xAddressIn, bus_b.yAddressIn}, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    chk("t1_writes", wr_b, 50);
    chk("t1_order", mis_b, 0);
    chk("t1_no_start", starts_b, 0);
    chk("t1_ready", bus_b.pixReady, 1);
    wr_b = 0;

    // Full default frame with random valid gaps.
    for (int i = 0; i < 19200; i++) begin
      while ($urandom_range(1, 0) == 1) idle(1);
      send_b(8'($urandom), (i == 0), 8'($urandom), 8'(i % 160), 8'(i / 160));
    end
    idle(4);
    chk("t6_writes", wr_b, 19200);
    chk("t6_order", mis_b, 0);
    chk("t6_pending", eq_b.size(), 0);
    chk("t6_last_xy", {lastx_b, lasty_b}, {8'd159, 8'd119});
    chk("t6_starts", starts_b, 1);
    chk("t6_busy", bus_b.busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule
